page_select_ctrl: RTL

- Parametrised successor to the 3-button display page selector.
- Selects one of NUM_PAGES DATA_W-bit data pages for the 7-segment driver.
- Buttons are synchronised, debounced and edge-detected; next/prev wrap around; home returns to page 0.
- Sits between the datapath (register file, PC/instruction, ALU result pages) and the display scanner.

---
 rtl/page_select_ctrl_if.sv | 35 +++
 rtl/page_select_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/page_select_ctrl_if.sv
// Bus between the page selector and its surroundings: raw buttons and pages in, display word and page index out.
// auto_mode is present only when AUTO_SCROLL_EN is defined.
interface page_select_ctrl_if #(
  parameter int NUM_PAGES = 3,
  parameter int DATA_W    = 32
);
  localparam int PAGE_W = $clog2(NUM_PAGES);

  logic                        btn_next;
  logic                        btn_prev;
  logic                        btn_home;
  logic [NUM_PAGES*DATA_W-1:0] page_in;
`ifdef AUTO_SCROLL_EN
  logic                        auto_mode;
`endif
  logic [DATA_W-1:0]           N;
  logic [PAGE_W-1:0]           status;
  logic                        page_changed;

  modport master (
    output btn_next, btn_prev, btn_home, page_in,
`ifdef AUTO_SCROLL_EN
    output auto_mode,
`endif
    input  N, status, page_changed
  );

  modport slave (
    input  btn_next, btn_prev, btn_home, page_in,
`ifdef AUTO_SCROLL_EN
    input  auto_mode,
`endif
    output N, status, page_changed
  );
endinterface

// File: rtl/page_select_ctrl.sv
// Display page selector: synchronised, debounced next/prev/home buttons pick one of NUM_PAGES words for N.
// Optional timed auto-scroll is built when AUTO_SCROLL_EN is defined.
module page_select_ctrl #(
  parameter int NUM_PAGES    = 3,
  parameter int DATA_W       = 32,
  parameter int DEBOUNCE_CYC = 16,
  parameter int SCROLL_CYC   = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  page_select_ctrl_if.slave bus
);
  localparam int PAGE_W = $clog2(NUM_PAGES);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);

  typedef enum logic [1:0] {IDLE, CHK_H, HELD, CHK_L} db_state_t;

  // Button order: 0 = next, 1 = prev, 2 = home
  logic [2:0] raw;
  logic [2:0] ev;

  assign raw = {bus.btn_home, bus.btn_prev, bus.btn_next};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic             sync1;
    logic             sync2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             ev_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= raw[b];
        sync2 <= sync1;
      end
    end

    // The cycle that leaves IDLE/HELD already counts as the first stable cycle
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        cnt   <= '0;
        ev_q  <= 1'b0;
      end else begin
        ev_q <= 1'b0;
        case (state)
          IDLE: begin
            if (sync2) begin
              if (DEBOUNCE_CYC == 1) begin
                state <= HELD;
                ev_q  <= 1'b1;
              end else begin
                state <= CHK_H;
                cnt   <= CNT_W'(1);
              end
            end
          end
          CHK_H: begin
            if (!sync2) begin
              state <= IDLE;
            end else if (cnt == CNT_LAST) begin
              state <= HELD;
              ev_q  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!sync2) begin
              if (DEBOUNCE_CYC == 1) begin
                state <= IDLE;
              end else begin
                state <= CHK_L;
                cnt   <= CNT_W'(1);
              end
            end
          end
          CHK_L: begin
            if (sync2) begin
              state <= HELD;
            end else if (cnt == CNT_LAST) begin
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign ev[b] = ev_q;
  end

  logic              any_ev;
  logic              tick;
  logic [PAGE_W-1:0] status_q;
  logic [PAGE_W-1:0] status_d;
  logic [PAGE_W-1:0] status_inc;
  logic [PAGE_W-1:0] status_dec;
  logic              changed_q;
  logic [DATA_W-1:0] n_q;
  logic [DATA_W-1:0] page_sel;

  assign any_ev = |ev;

`ifdef AUTO_SCROLL_EN
  localparam int TMR_W = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCROLL_CYC - 1);

  logic [TMR_W-1:0] timer;

  // Button events win over a coinciding expiry, which is then lost
  assign tick = bus.auto_mode && !any_ev && (timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (any_ev || !bus.auto_mode || timer == TMR_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end
`else
  assign tick = 1'b0;
`endif

  assign status_inc = (status_q == LAST_PAGE) ? '0 : status_q + 1'b1;
  assign status_dec = (status_q == '0) ? LAST_PAGE : status_q - 1'b1;

  always_comb begin
    status_d = status_q;
    if (ev[2]) begin
      status_d = '0;
    end else if (ev[0]) begin
      status_d = status_inc;
    end else if (ev[1]) begin
      status_d = status_dec;
    end else if (tick) begin
      status_d = status_inc;
    end
  end

  // Compare-based mux keeps every read inside the legal page range
  always_comb begin
    page_sel = '0;
    for (int unsigned k = 0; k < NUM_PAGES; k++) begin
      if (status_q == PAGE_W'(k)) begin
        page_sel = bus.page_in[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q  <= '0;
      changed_q <= 1'b0;
      n_q       <= '0;
    end else begin
      status_q  <= status_d;
      changed_q <= (status_d != status_q);
      n_q       <= page_sel;
    end
  end

  assign bus.status       = status_q;
  assign bus.page_changed = changed_q;
  assign bus.N            = n_q;
endmodule
